// File: rtl/cla_multiword_sequencer_pkg.sv
// Shared types and helpers for the multi-word carry-lookahead sequencer.
// State encoding, the slice-counter width function and the default slice geometry.
package cla_multiword_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_N = 4;
    localparam int DEF_K = 4;

    function automatic int cnt_width(input int k);
        return (k <= 1) ? 1 : $clog2(k);
    endfunction

endpackage

// File: rtl/cla_multiword_sequencer_if.sv
// Request/result bus of the multi-word sequencer. The sub signal exists only
// when SUBTRACT_EN is defined.
interface cla_multiword_sequencer_if
    import cla_multiword_sequencer_pkg::*;
    #(parameter int W = DEF_N * DEF_K);

    // A transfer happens on a rising edge where valid && ready. The producer holds
    // its payload stable while valid is high; ready may depend on state but never on valid.
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef SUBTRACT_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;

    modport master (
`ifdef SUBTRACT_EN
        output sub,
`endif
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
`ifdef SUBTRACT_EN
        input  sub,
`endif
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );

endinterface

// File: rtl/cla_multiword_sequencer_cla.sv
// N-bit gate-level carry-lookahead adder; every carry is a flat
// generate/propagate sum-of-products rather than a ripple chain.
module carry_look_ahead_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
    always_comb begin
        logic acc;
        logic prod;
        c    = '0;
        acc  = 1'b0;
        prod = 1'b0;
        c[0] = cin;
        for (int i = 0; i < N; i++) begin
            acc  = g[i];
            prod = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc  = acc | (prod & g[j]);
                prod = prod & p[j];
            end
            c[i+1] = acc | (prod & cin);
        end
    end

    assign sum  = p ^ c[N-1:0];
    assign cout = c[N];

endmodule

// File: rtl/cla_multiword_sequencer.sv
// Wide adder that streams K slices of N bits, LSB first, through one CLA slice.
// Optional feature macro: SUBTRACT_EN (adds a sub request computing a - b).
module cla_multiword_sequencer
    import cla_multiword_sequencer_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int K = DEF_K
) (
    input  logic   clk,
    input  logic   rst_n,
    cla_multiword_sequencer_if.slave bus,
    output logic   busy,
    output state_t dbg_state
);

    localparam int W  = N * K;
    localparam int CW = cnt_width(K);
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          carry_q;
    logic [W-1:0]  a_q, b_q, sum_q, sum_shifted;
    logic          cout_q;
    logic [N-1:0]  slice_sum;
    logic          slice_cout;
    logic          do_sub;
    logic          accept;

`ifdef SUBTRACT_EN
    assign do_sub = bus.sub;
`else
    assign do_sub = 1'b0;
`endif

    carry_look_ahead_adder #(.N(N)) u_slice (
        .a    (a_q[N-1:0]),
        .b    (b_q[N-1:0]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Each slice result enters at the MSB end, so after K shifts slice 0 sits at the bottom.
    generate
        if (K == 1) begin : g_single
            assign sum_shifted = slice_sum;
        end else begin : g_multi
            assign sum_shifted = {slice_sum, sum_q[W-1:N]};
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.in_valid)   state_nxt = ST_RUN;
            ST_RUN:  if (cnt == LAST)    state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready)  state_nxt = ST_IDLE;
            default:                     state_nxt = ST_IDLE;
        endcase
    end

    assign accept        = (state == ST_IDLE) && bus.in_valid;
    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign busy          = (state == ST_RUN) || (state == ST_DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign dbg_state     = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            carry_q <= 1'b0;
            cnt     <= '0;
        end else if (accept) begin
            a_q     <= bus.a;
            b_q     <= do_sub ? ~bus.b : bus.b;
            carry_q <= do_sub ? 1'b1 : bus.cin;
            cnt     <= '0;
        end else if (state == ST_RUN) begin
            a_q     <= a_q >> N;
            b_q     <= b_q >> N;
            sum_q   <= sum_shifted;
            carry_q <= slice_cout;
            cnt     <= cnt + CW'(1);
            if (cnt == LAST) cout_q <= slice_cout;
        end
    end

endmodule
